// File: rtl/inv_norm_arbiter.sv
// Round-robin arbiter sharing one pipelined inverse-norm unit between N requesters.
// An in-order tag FIFO records each issuer so every unit result is routed back to it.
module inv_norm_arbiter #(
  parameter int N         = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N-1:0]               req_valid,
  input  logic [N*32-1:0]            req_data,
  output logic [N-1:0]               req_ready,
  output logic                       unit_valid,
  output logic [31:0]                unit_data,
  input  logic [31:0]                unit_d_out,
  input  logic [5:0]                 unit_scale,
  input  logic                       unit_valid_out,
  output logic [N-1:0]               rsp_valid,
  output logic [31:0]                rsp_data,
  output logic [5:0]                 rsp_scale,
  output logic [$clog2(TAG_DEPTH):0] outstanding,
  output logic                       err_orphan
);
  localparam int IDW = $clog2(N);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam logic [IDW:0] N_EXT = (IDW+1)'(N);
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, rr_next_s;
  logic [PW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]    cnt_q, cnt_d;
  logic [IDW-1:0] tag_mem_q [TAG_DEPTH];
  logic           unit_valid_q;
  logic [31:0]    unit_data_q, unit_data_d;
  logic [N-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic [5:0]     rsp_scale_q, rsp_scale_d;
  logic           err_orphan_q, err_orphan_d;

  logic [2*N-1:0] req_dbl_s;
  logic [N-1:0]   req_rot_s;
  logic           any_s;
  logic [IDW:0]   win_sum_s;
  logic [IDW-1:0] win_idx_s;
  logic [IDW-1:0] head_s;
  logic [31:0]    sel_data_s;
  logic           full_s, empty_s, push_s, pop_s;

  // Rotate requests so rr_ptr sits at bit 0; the lowest set bit of the rotation wins.
  always_comb begin
    req_dbl_s = {req_valid, req_valid} >> rr_ptr_q;
    req_rot_s = req_dbl_s[N-1:0];
    any_s     = 1'b0;
    win_sum_s = '0;
    for (int j = N - 1; j >= 0; j--) begin
      win_sum_s = req_rot_s[j] ? ({1'b0, rr_ptr_q} + (IDW+1)'(j)) : win_sum_s;
      any_s     = any_s | req_rot_s[j];
    end
    if (win_sum_s >= N_EXT) begin
      win_idx_s = IDW'(win_sum_s - N_EXT);
    end else begin
      win_idx_s = win_sum_s[IDW-1:0];
    end
  end

  // Winner data mux.
  always_comb begin
    sel_data_s = 32'h0000_0000;
    for (int j = 0; j < N; j++) begin
      sel_data_s = (IDW'(j) == win_idx_s) ? req_data[j*32 +: 32] : sel_data_s;
    end
  end

  assign full_s  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign empty_s = (wptr_q == rptr_q);
  assign head_s  = tag_mem_q[rptr_q[PW-1:0]];

  // Grant is withheld while the tag FIFO is full, with no same-cycle pop bypass.
  always_comb begin
    if (nrst && !full_s && any_s) begin
      req_ready = ONE_N << win_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  assign push_s = |(req_valid & req_ready);
  assign pop_s  = unit_valid_out & ~empty_s;

  // Next-state for pointers, counters and the registered response bus.
  always_comb begin
    rr_next_s    = (win_idx_s == IDW'(N - 1)) ? '0 : (win_idx_s + IDW'(1));
    rr_ptr_d     = push_s ? rr_next_s : rr_ptr_q;
    wptr_d       = push_s ? (wptr_q + (PW+1)'(1)) : wptr_q;
    rptr_d       = pop_s  ? (rptr_q + (PW+1)'(1)) : rptr_q;
    unit_data_d  = push_s ? sel_data_s : unit_data_q;
    rsp_valid_d  = pop_s  ? (ONE_N << head_s) : '0;
    rsp_data_d   = pop_s  ? unit_d_out : rsp_data_q;
    rsp_scale_d  = pop_s  ? unit_scale : rsp_scale_q;
    err_orphan_d = err_orphan_q | (unit_valid_out & empty_s);
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr_q     <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      unit_valid_q <= 1'b0;
      unit_data_q  <= 32'h0000_0000;
      rsp_valid_q  <= '0;
      rsp_data_q   <= 32'h0000_0000;
      rsp_scale_q  <= 6'h00;
      err_orphan_q <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      unit_valid_q <= push_s;
      unit_data_q  <= unit_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_scale_q  <= rsp_scale_d;
      err_orphan_q <= err_orphan_d;
      if (push_s) begin
        tag_mem_q[wptr_q[PW-1:0]] <= win_idx_s;
      end
    end
  end

  assign unit_valid  = unit_valid_q;
  assign unit_data   = unit_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_scale   = rsp_scale_q;
  assign outstanding = cnt_q;
  assign err_orphan  = err_orphan_q;

endmodule
